min_share_arb: RTL and testbench
================================

# min_share_arb

Shared minimum-compare unit with round-robin arbitration. Up to N requesters each present an unsigned operand pair (a, b) on a valid/ready channel. The block grants one requester per cycle and computes the registered unsigned minimum in a single shared compare stage. It returns the result tagged with the winning requester's index on one valid/ready response channel. It is the block that shares our registered min datapath between several clients, replacing one compare instance per client.

## Interface
- N, default 4: number of requesters, 2..16.
- W, default 8: operand and result width.
- IDW, default 2: response tag width; must equal clog2(N).

- clk  in  1: single clock; all state on rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- req_valid  in  N: bit i set means requester i presents an operand pair.
- req_a  in  N*W: operand a of requester i at bits [i*W +: W].
- req_b  in  N*W: operand b of requester i at bits [i*W +: W].
- req_ready  out  N: one-hot or zero; bit i set means requester i's pair is accepted this cycle.
- rsp_valid  out  1: result register holds a valid result.
- rsp_d  out  W: min(a, b) of the granted pair.
- rsp_id  out  IDW: index of the requester that produced rsp_d.
- rsp_ready  in  1: consumer accepts the result this cycle.

## Operation
- load = !rsp_valid || rsp_ready. The result register may be written only when load is 1.
- Winner: the requester chosen by the arbitration rule among those with req_valid set. It is evaluated combinationally every cycle.
- req_ready[i] = load && winner==i && req_valid[i]. At most one bit is set. req_ready depends combinationally on req_valid and rsp_ready; the path contains no registers.
- Transfer on requester i occurs when req_valid[i] && req_ready[i]. On that edge:
  - rsp_d <= (a < b) ? a : b, unsigned compare. When a == b, the result is a.
  - rsp_id <= i.
  - rsp_valid <= 1.
- On a load cycle with no req_valid set: rsp_valid <= 0. rsp_d and rsp_id hold their values but are don't-care.
- When rsp_valid && !rsp_ready: the result register, rsp_d and rsp_id hold. All req_ready bits are 0.
- Arbitration pointer ptr (IDW bits) records the last granted index.
  - It updates only on a transfer, never on idle or stalled cycles.
  - Search order: ptr+1, ptr+2, ..., wrapping modulo N, with ptr itself last.
  - Wrap handles non-power-of-two N: the index after N-1 is 0.
- Requesters must hold req_valid, req_a and req_b stable until their transfer.
  - The block does not check this.
  - Withdrawing a request before transfer is permitted; the block simply does not grant it.

## Timing
- Reset values (asynchronous, immediate on rst_n low): rsp_valid=0, rsp_d=0, rsp_id=0, ptr=N-1. With ptr=N-1, requester 0 has top priority after reset. req_ready follows combinationally: it is all ones-free, meaning at most the winner once rsp_valid=0.
- Latency: the transfer edge produces rsp_valid on that same edge. The result is visible one cycle after the req_ready/req_valid handshake.
- Throughput: one result per cycle while rsp_ready is held high.
- Simultaneous events: a rsp_ready && rsp_valid handshake and a new request transfer on the same edge. The old result is consumed and the new one is loaded; there is no bubble.
- Reset mid-operation discards the in-flight result. No response is generated for it, and the pointer returns to N-1.
- Fairness: with all N requesters permanently valid and rsp_ready=1, grants cycle 0,1,...,N-1,0. Every requester is served within N transfers.

## Configuration
- MIN_SHARE_ARB_RR_EN
  - Defined: round-robin arbitration using ptr, as described above.
  - Undefined: fixed priority; the lowest-index valid requester wins. ptr and its logic are compiled out. Starvation of high indices is then permitted.
- Handshake, latency and reset behaviour are identical in both builds.

## Test plan
- Single request: reset, then req_valid=0001, a0=0x35, b0=0x12, rsp_ready=1. Required: req_ready=0001 for one cycle. Next cycle rsp_valid=1, rsp_d=0x12, rsp_id=0.
- Equal and extreme operands: requester 2 issues a=b=0x80, then a=0xFF, b=0x00. Required: rsp_d=0x80, then rsp_d=0x00, both with rsp_id=2. The compare must be unsigned.
- Round-robin (RR_EN): all four valid, rsp_ready=1 for 8 cycles. Required: rsp_id sequence 0,1,2,3,0,1,2,3. Without the macro: 0,0,0,0,0,0,0,0.
- Backpressure: a result is pending and rsp_ready=0 for 3 cycles while requesters 1 and 3 are valid. Required:
  - req_ready=0 throughout.
  - rsp_d and rsp_id are stable.
  - On rsp_ready=1, the pending result is consumed and requester 1 is granted on the same edge, with no bubble.
- Idle drain: a single transfer followed by req_valid=0 with rsp_ready=1. Required: rsp_valid is 1 for exactly one cycle, then 0, and ptr is unchanged.
- Reset mid-stream: assert rst_n=0 while rsp_valid=1, away from a clock edge. Required:
  - rsp_valid=0 immediately.
  - After release, the first grant goes to the lowest valid index (RR build).

Source files
------------

// File: rtl/min_share_arb.sv
// rtl/min_share_arb.sv - shared registered unsigned min unit with N-way request arbitration
// MIN_SHARE_ARB_RR_EN selects round-robin arbitration; undefined gives fixed lowest-index priority.
module min_share_arb #(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  output logic [N-1:0]   req_ready,
  output logic           rsp_valid,
  output logic [W-1:0]   rsp_d,
  output logic [IDW-1:0] rsp_id,
  input  logic           rsp_ready
);

  logic           load;
  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] cand;
  logic [W-1:0]   sel_a;
  logic [W-1:0]   sel_b;
  logic [W-1:0]   min_ab;
  logic           xfer;

  assign load = !rsp_valid || rsp_ready;
  assign xfer = load && win_found;

`ifdef MIN_SHARE_ARB_RR_EN
  logic [IDW-1:0] ptr;

  // Scan starts just after the last grant and visits ptr itself last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDW'((int'(ptr) + k) % N);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= IDW'(N - 1);
    end else if (xfer) begin
      ptr <= win_idx;
    end
  end
`else
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = IDW'(k);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end
`endif

  always_comb begin
    req_ready = '0;
    if (xfer) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N; i++) begin
      if (win_idx == IDW'(i)) begin
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
      end
    end
  end

  // Ties resolve to operand a.
  assign min_ab = (sel_a < sel_b) ? sel_a : sel_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_d     <= '0;
      rsp_id    <= '0;
    end else if (load) begin
      rsp_valid <= win_found;
      if (win_found) begin
        rsp_d  <= min_ab;
        rsp_id <= win_idx;
      end
    end
  end

endmodule

// File: tb/tb_min_share_arb.sv
// tb/tb_min_share_arb.sv - directed and random checks of min_share_arb against a transaction model
module tb_min_share_arb;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [W-1:0]   rsp_d;
  logic [IDW-1:0] rsp_id;
  logic           rsp_ready;

  int checks = 0;
  int errors = 0;

  bit       m_valid;
  logic [7:0] m_d;
  int       m_id;
  int       m_last;

  min_share_arb #(.N(N), .W(W), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_d     (rsp_d),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_winner(input logic [N-1:0] v, input int last);
    int c;
`ifdef MIN_SHARE_ARB_RR_EN
    for (int k = 1; k <= N; k++) begin
      c = (last + k) % N;
      if (v[c[1:0]]) return c;
    end
`else
    for (int k = 0; k < N; k++) begin
      c = k + (last - last);
      if (v[c[1:0]]) return c;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_d     = 8'h00;
    m_id    = 0;
    m_last  = N - 1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  // One clock: check the combinational grant, then the registered response.
  task automatic cycle();
    int         w;
    bit         load;
    logic [N-1:0] er;
    logic [7:0] a;
    logic [7:0] b;
    load = !m_valid || rsp_ready;
    w    = model_winner(req_valid, m_last);
    er   = (load && w >= 0) ? N'(1 << w) : '0;
    #1;
    chk("req_ready", 32'(req_ready), 32'(er));
    @(posedge clk);
    if (load) begin
      if (w >= 0) begin
        a       = req_a[w*W +: W];
        b       = req_b[w*W +: W];
        m_valid = 1'b1;
        m_d     = (b < a) ? b : a;
        m_id    = w;
        m_last  = w;
      end else begin
        m_valid = 1'b0;
      end
    end
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    if (m_valid) begin
      chk("rsp_d", 32'(rsp_d), 32'(m_d));
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
    end
  endtask

  initial begin
    clk       = 1'b0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_d", 32'(rsp_d), 32'd0);
    chk("reset_rsp_id", 32'(rsp_id), 32'd0);
    chk("reset_req_ready_idle", 32'(req_ready), 32'd0);
    rst_n = 1'b1;

    // Single request
    set_op(0, 8'h35, 8'h12);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    cycle();
    chk("single_d", 32'(rsp_d), 32'h12);
    chk("single_id", 32'(rsp_id), 32'd0);
    req_valid = '0;
    cycle();

    // Equal and extreme operands on requester 2
    set_op(2, 8'h80, 8'h80);
    req_valid = 4'b0100;
    cycle();
    chk("equal_d", 32'(rsp_d), 32'h80);
    chk("equal_id", 32'(rsp_id), 32'd2);
    set_op(2, 8'hFF, 8'h00);
    cycle();
    chk("extreme_d", 32'(rsp_d), 32'h00);
    chk("extreme_id", 32'(rsp_id), 32'd2);
    req_valid = '0;
    cycle();

    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // All requesters valid: fairness sequence
    for (int i = 0; i < N; i++) set_op(i, 8'($urandom), 8'($urandom));
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      cycle();
`ifdef MIN_SHARE_ARB_RR_EN
      chk("rr_sequence_id", 32'(rsp_id), 32'(i % N));
`else
      chk("fixed_sequence_id", 32'(rsp_id), 32'd0);
`endif
    end

    // Backpressure with requesters 1 and 3 waiting
    req_valid = 4'b0001;
    cycle();
    rsp_ready = 1'b0;
    req_valid = 4'b1010;
    repeat (3) cycle();
    rsp_ready = 1'b1;
    cycle();
    chk("bp_release_valid", 32'(rsp_valid), 32'd1);
    chk("bp_release_id", 32'(rsp_id), 32'd1);

    // Idle drain leaves the pointer alone
    req_valid = '0;
    cycle();
    chk("drain_valid", 32'(rsp_valid), 32'd0);
    cycle();
    req_valid = 4'b1111;
    #1;
`ifdef MIN_SHARE_ARB_RR_EN
    chk("drain_ptr_hold", 32'(req_ready), 32'b0100);
`else
    chk("drain_ptr_hold", 32'(req_ready), 32'b0001);
`endif
    cycle();

    // Random traffic, including withdrawn requests and stalls
    for (int n = 0; n < 300; n++) begin
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) set_op(i, 8'($urandom), 8'($urandom));
      rsp_ready = ($urandom % 4) != 0;
      cycle();
    end

    // Reset while a result is held
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    cycle();
    chk("pre_reset_valid", 32'(rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 32'(rsp_valid), 32'd0);
    chk("async_reset_d", 32'(rsp_d), 32'd0);
    chk("async_reset_id", 32'(rsp_id), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = 4'b0110;
    rsp_ready = 1'b1;
    cycle();
    chk("post_reset_first_id", 32'(rsp_id), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
